dma_chan_scheduler: RTL and testbench

//  Sequences the DMAC by arbitrating among NCH peripheral DMA request lines (I2S RX FIFO, UART TX FIFO, ...).

---
 rtl/dma_chan_scheduler.sv | 143 ++++++++++++++
 tb/tb_dma_chan_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_chan_scheduler.sv
// DMA channel scheduler: arbitrates peripheral request lines (high-priority group first,
// round-robin within a group), issues one DMAC start per grant, waits for done and acks.
module dma_chan_scheduler #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned TMO_W = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NCH-1:0]           req,
  input  logic [NCH-1:0]           ch_en,
  input  logic [NCH-1:0]           ch_hi,
  input  logic [NCH*LEN_W-1:0]     cfg_len,
  output logic                     dmac_start,
  output logic [$clog2(NCH)-1:0]   dmac_ch,
  output logic [LEN_W-1:0]         dmac_len,
  input  logic                     dmac_done,
  output logic [NCH-1:0]           ack,
  output logic                     busy,
  output logic                     err_tmo,
  input  logic                     err_clr
);

  localparam int unsigned CH_W = $clog2(NCH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr, rr_d;
  logic [TMO_W-1:0]  tmo_cnt, tmo_d;
  logic [CH_W-1:0]   ch_d;
  logic [LEN_W-1:0]  len_d;
  logic              err_d;
  logic              expire;

  logic [LEN_W-1:0]  len_arr [NCH];
  logic [NCH-1:0]    elig;
  logic [NCH-1:0]    pool;
  logic              found;
  logic [CH_W-1:0]   win;

  // Per-channel eligibility: requesting, enabled and a non-zero burst configured
  for (genvar g = 0; g < NCH; g++) begin : g_elig
    assign len_arr[g] = cfg_len[g*LEN_W +: LEN_W];
    assign elig[g]    = req[g] & ch_en[g] & (len_arr[g] != '0);
  end

  assign pool = (|(elig & ch_hi)) ? (elig & ch_hi) : elig;

  // Round-robin search from rr_ptr; the modulo wrap is explicit so odd NCH works
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      int unsigned idx;
      idx = 32'(rr_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && pool[CH_W'(idx)]) begin
        found = 1'b1;
        win   = CH_W'(idx);
      end
    end
  end

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == CH_W'(NCH - 1)) ? '0 : c + CH_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    rr_d    = rr_ptr;
    tmo_d   = tmo_cnt;
    ch_d    = dmac_ch;
    len_d   = dmac_len;
    expire  = 1'b0;
    unique case (state_q)
      S_IDLE: if (|elig) state_d = S_ARB;
      S_ARB: begin
        if (found) begin
          ch_d    = win;
          len_d   = len_arr[win];
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_cnt + TMO_W'(1);
        if (dmac_done) begin
          state_d = S_ACK;
        end else if (tmo_d == '1) begin
          expire  = 1'b1;
          rr_d    = next_ch(dmac_ch);
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        rr_d    = next_ch(dmac_ch);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_tmo;
    if (expire)       err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      rr_ptr     <= '0;
      tmo_cnt    <= '0;
      dmac_start <= 1'b0;
      dmac_ch    <= '0;
      dmac_len   <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr     <= rr_d;
      tmo_cnt    <= tmo_d;
      dmac_start <= (state_d == S_START);
      dmac_ch    <= ch_d;
      dmac_len   <= len_d;
      ack        <= (state_d == S_ACK) ? (NCH'(1) << ch_d) : '0;
      busy       <= (state_d != S_IDLE);
      err_tmo    <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_chan_scheduler.sv
// Bench for dma_chan_scheduler: vector table of grants with a start/ack scoreboard,
// plus hand sequences for zero-length/disabled channels, timeout and reset abort.
module tb_dma_chan_scheduler;

  localparam int unsigned NCH   = 4;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned TMO_W = 4;

  logic                   HCLK = 1'b0;
  logic                   HRESET;
  logic [NCH-1:0]         req, ch_en, ch_hi;
  logic [NCH*LEN_W-1:0]   cfg_len;
  logic                   dmac_start;
  logic [1:0]             dmac_ch;
  logic [LEN_W-1:0]       dmac_len;
  logic                   dmac_done;
  logic [NCH-1:0]         ack;
  logic                   busy;
  logic                   err_tmo;
  logic                   err_clr;

  dma_chan_scheduler #(.NCH(NCH), .LEN_W(LEN_W), .TMO_W(TMO_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .ch_en(ch_en), .ch_hi(ch_hi),
    .cfg_len(cfg_len), .dmac_start(dmac_start), .dmac_ch(dmac_ch), .dmac_len(dmac_len),
    .dmac_done(dmac_done), .ack(ack), .busy(busy), .err_tmo(err_tmo), .err_clr(err_clr)
  );

  always #5 HCLK = ~HCLK;

  localparam logic [NCH*LEN_W-1:0] LENS = {8'h43, 8'h32, 8'h21, 8'h10};

  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
    logic [3:0] hi;
    int         ch;
    int         len;
    int         dly;
  } vec_t;

  typedef struct {
    int ch;
    int len;
  } start_t;

  int total = 0;
  int bad   = 0;
  start_t     start_q[$];
  logic [3:0] ack_q[$];
  vec_t       vecs[14];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    HRESET = 1'b1; req = '0; ch_en = '0; ch_hi = '0; cfg_len = LENS;
    dmac_done = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!dmac_start && n < 20);
  endtask

  // One complete grant: start expected 2 cycles after request, done after dly WAIT cycles
  task automatic xfer(input logic [3:0] r, input logic [3:0] en, input logic [3:0] hi,
                      input int ch, input int len, input int dly);
    int n;
    start_t e;
    logic [3:0] ea;
    req = r; ch_en = en; ch_hi = hi;
    start_q.push_back('{ch: ch, len: len});
    wait_start(n);
    chk("start_latency", n, 2);
    e = start_q.pop_front();
    if (!dmac_start) begin
      req = '0;
      return;
    end
    chk("start_ch", 32'(dmac_ch), e.ch);
    chk("start_len", 32'(dmac_len), e.len);
    req = '0;
    for (int i = 0; i < dly; i++) begin
      @(negedge HCLK);
      if (i == 0) chk("start_one_cycle", 32'(dmac_start), 0);
    end
    chk("wait_ch", 32'(dmac_ch), e.ch);
    dmac_done = 1'b1;
    ack_q.push_back(4'(1 << ch));
    @(negedge HCLK);
    dmac_done = 1'b0;
    ea = ack_q.pop_front();
    chk("ack", 32'(ack), 32'(ea));
    chk("err_clean", 32'(err_tmo), 0);
    @(negedge HCLK);
    chk("ack_pulse", 32'(ack), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int n;
    logic seen_start, seen_busy, seen_ack;

    vecs = '{
      '{4'b1111, 4'b1111, 4'b0000, 0, 'h10, 3},
      '{4'b1111, 4'b1111, 4'b0000, 1, 'h21, 4},
      '{4'b1111, 4'b1111, 4'b0000, 2, 'h32, 5},
      '{4'b1111, 4'b1111, 4'b0000, 3, 'h43, 1},
      '{4'b1111, 4'b1111, 4'b0000, 0, 'h10, 2},
      '{4'b1111, 4'b1111, 4'b0100, 2, 'h32, 3},
      '{4'b1111, 4'b1111, 4'b0100, 2, 'h32, 3},
      '{4'b1111, 4'b1111, 4'b0100, 2, 'h32, 3},
      '{4'b1011, 4'b1111, 4'b0100, 3, 'h43, 2},
      '{4'b0110, 4'b1111, 4'b0000, 1, 'h21, 2},
      '{4'b1111, 4'b1111, 4'b1001, 3, 'h43, 2},
      '{4'b1111, 4'b1111, 4'b1001, 0, 'h10, 15},
      '{4'b0101, 4'b1110, 4'b0000, 2, 'h32, 1},
      '{4'b1011, 4'b0111, 4'b1000, 0, 'h10, 2}
    };

    // Reset values and single-channel latency
    do_reset();
    chk("rst_start", 32'(dmac_start), 0);
    chk("rst_ch", 32'(dmac_ch), 0);
    chk("rst_len", 32'(dmac_len), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_tmo), 0);
    xfer(4'b0001, 4'b1111, 4'b0000, 0, 'h10, 10);

    // Round-robin, priority groups, done-vs-expiry tie
    do_reset();
    for (int v = 0; v < 14; v++)
      xfer(vecs[v].req, vecs[v].en, vecs[v].hi, vecs[v].ch, vecs[v].len, vecs[v].dly);

    // Zero-length and disabled channels never start
    for (int m = 0; m < 2; m++) begin
      cfg_len = LENS;
      if (m == 0) cfg_len[LEN_W +: LEN_W] = '0;
      ch_en = (m == 0) ? 4'b1111 : 4'b1101;
      req = 4'b0010;
      seen_start = 1'b0; seen_busy = 1'b0;
      repeat (8) begin
        @(negedge HCLK);
        seen_start |= dmac_start;
        seen_busy  |= busy;
      end
      chk(m == 0 ? "zero_len_start" : "disabled_start", 32'(seen_start), 0);
      chk(m == 0 ? "zero_len_busy" : "disabled_busy", 32'(seen_busy), 0);
    end
    req = '0; cfg_len = LENS; ch_en = 4'b1111;

    // Stray done while idle
    dmac_done = 1'b1;
    @(negedge HCLK);
    dmac_done = 1'b0;
    chk("stray_done_ack", 32'(ack), 0);
    chk("stray_done_busy", 32'(busy), 0);

    // Watchdog timeout after 15 WAIT cycles
    req = 4'b0001;
    wait_start(n);
    chk("tmo_latency", n, 2);
    req = '0;
    seen_ack = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge HCLK);
      seen_ack |= (ack != '0);
      if (i == 15) begin
        chk("tmo_busy_before", 32'(busy), 1);
        chk("tmo_err_before", 32'(err_tmo), 0);
      end
    end
    chk("tmo_err", 32'(err_tmo), 1);
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_no_ack", 32'(seen_ack), 0);
    repeat (3) @(negedge HCLK);
    chk("tmo_sticky", 32'(err_tmo), 1);
    err_clr = 1'b1;
    @(negedge HCLK);
    err_clr = 1'b0;
    chk("tmo_clear", 32'(err_tmo), 0);
    xfer(4'b0011, 4'b1111, 4'b0000, 1, 'h21, 2);

    // Reset during WAIT aborts; late done produces no ack
    req = 4'b0100;
    wait_start(n);
    chk("abort_latency", n, 2);
    req = '0;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_start", 32'(dmac_start), 0);
    chk("abort_ch", 32'(dmac_ch), 0);
    chk("abort_len", 32'(dmac_len), 0);
    chk("abort_ack", 32'(ack), 0);
    HRESET = 1'b0;
    @(negedge HCLK);
    dmac_done = 1'b1;
    @(negedge HCLK);
    dmac_done = 1'b0;
    chk("late_done_ack", 32'(ack), 0);
    @(negedge HCLK);
    chk("late_done_ack2", 32'(ack), 0);
    chk("late_done_busy", 32'(busy), 0);
    xfer(4'b1111, 4'b1111, 4'b0000, 0, 'h10, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
